uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_receiver.sv | 119 +++++++++++
 tb/tb_uart_receiver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to receiver and transmitter),
// default bit timing and character width.
// Latency: n/a (declarations only). Backpressure: n/a.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 1 (line idle).
// Latency: 2 clk cycles from d to q.
// Backpressure: none, free-running.
// Ports: clk - clock; reset - async active-low; d - async input; q - synchronized output.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, framing-error detection, break lock-out.
// Latency: Rx falling edge to RxListo pulse = 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles.
// Backpressure: none; data holds the last good byte until the next one overwrites it.
// Ports: clk, reset (async active-low), Rx (serial in, idle high), data (last good byte),
//        RxListo (1-cycle pulse on new data), ErrorTrama (1-cycle pulse on bad stop bit),
//        Ocupado (high whenever the FSM is not in IDLE).
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 RxListo,
    output logic                 ErrorTrama,
    output logic                 Ocupado
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rxs;
    uart_state_t          state;
    uart_state_t          state_nxt;
    logic [TW-1:0]        tick;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shift;
    logic                 tick_last;
    logic                 half_last;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (Rx),
        .q     (rxs)
    );

    assign tick_last = (tick == TICK_LAST);
    assign half_last = (tick == HALF_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rxs) state_nxt = START;
            // Re-check the start bit at its middle to reject short glitches.
            START:     if (half_last) state_nxt = rxs ? IDLE : DATA;
            DATA:      if (tick_last && idx == IDX_LAST) state_nxt = STOP;
            STOP:      if (tick_last) state_nxt = rxs ? IDLE : WAIT_HIGH;
            // A held-low line (break) must return high before a new start is accepted.
            WAIT_HIGH: if (rxs) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tick       <= '0;
            idx        <= '0;
            shift      <= '0;
            data       <= '0;
            RxListo    <= 1'b0;
            ErrorTrama <= 1'b0;
            Ocupado    <= 1'b0;
        end else begin
            state      <= state_nxt;
            // Registered copy of (state != IDLE), aligned with the state register.
            Ocupado    <= (state_nxt != IDLE);
            RxListo    <= 1'b0;
            ErrorTrama <= 1'b0;
            case (state)
                IDLE: begin
                    tick <= '0;
                    idx  <= '0;
                end
                START: begin
                    idx  <= '0;
                    tick <= half_last ? '0 : tick + TW'(1);
                end
                DATA: begin
                    // Counting restarts at mid start bit, so each wrap lands mid data bit.
                    if (tick_last) begin
                        tick       <= '0;
                        shift[idx] <= rxs;
                        idx        <= idx + 3'd1;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                STOP: begin
                    if (tick_last) begin
                        tick <= '0;
                        if (rxs) begin
                            data    <= shift;
                            RxListo <= 1'b1;
                        end else begin
                            ErrorTrama <= 1'b1;
                        end
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                WAIT_HIGH: begin
                    tick <= '0;
                    idx  <= '0;
                end
                default: begin
                    tick <= '0;
                    idx  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: good, glitch, framing-error, back-to-back,
// mid-frame reset and baud-skew frames with hand-computed expected bytes.
// Latency/backpressure: n/a (bench).
module tb_uart_receiver;

    localparam int CPB = 16;
    localparam int LAT_MIN = 2 + CPB / 2 + 9 * CPB - 1;
    localparam int LAT_MAX = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Rx = 1'b1;
    logic [7:0] data;
    logic       RxListo;
    logic       ErrorTrama;
    logic       Ocupado;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int rdy_cnt = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;
    int long_rdy_cnt = 0;
    int long_err_cnt = 0;
    int last_rdy_cyc = 0;
    int fall_cyc = 0;
    logic prev_rdy = 1'b0;
    logic prev_err = 1'b0;
    logic [7:0] rx_q[$];

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .Rx         (Rx),
        .data       (data),
        .RxListo    (RxListo),
        .ErrorTrama (ErrorTrama),
        .Ocupado    (Ocupado)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (RxListo) begin
            rdy_cnt      = rdy_cnt + 1;
            last_rdy_cyc = cyc;
            rx_q.push_back(data);
        end
        if (ErrorTrama) err_cnt = err_cnt + 1;
        if (RxListo && ErrorTrama) overlap_cnt = overlap_cnt + 1;
        if (RxListo && prev_rdy) long_rdy_cnt = long_rdy_cnt + 1;
        if (ErrorTrama && prev_err) long_err_cnt = long_err_cnt + 1;
        prev_rdy = RxListo;
        prev_err = ErrorTrama;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame; period_x100 is the bit period in hundredths of a cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int period_x100);
        logic v;
        int   dur;
        fall_cyc = cyc;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      v = 1'b0;
            else if (k == 9) v = stop_bit;
            else             v = b[k-1];
            dur = ((k + 1) * period_x100) / 100 - (k * period_x100) / 100;
            Rx = v;
            wait_cycles(dur);
        end
        Rx = 1'b1;
    endtask

    task automatic check_latency(input string tag);
        int lat;
        lat = last_rdy_cyc - fall_cyc;
        $display("%s latency = %0d cycles", tag, lat);
        check(tag, 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);
    endtask

    initial begin
        int base;

        // Reset state
        wait_cycles(5);
        check("rst_data", 32'(data), 32'h00);
        check("rst_rdy", 32'(RxListo), 32'd0);
        check("rst_err", 32'(ErrorTrama), 32'd0);
        check("rst_busy", 32'(Ocupado), 32'd0);
        reset = 1'b1;
        wait_cycles(5);

        // Good frame 0xA5
        send_frame(8'hA5, 1'b1, CPB * 100);
        wait_cycles(20);
        check("a5_pulses", 32'(rdy_cnt), 32'd1);
        check("a5_data", 32'(data), 32'hA5);
        check("a5_err", 32'(err_cnt), 32'd0);
        check_latency("a5_latency");

        // 4-cycle glitch while idle
        Rx = 1'b0;
        wait_cycles(4);
        Rx = 1'b1;
        wait_cycles(1);
        check("glitch_busy", 32'(Ocupado), 32'd1);
        wait_cycles(20);
        check("glitch_idle", 32'(Ocupado), 32'd0);
        check("glitch_pulses", 32'(rdy_cnt), 32'd1);
        check("glitch_data", 32'(data), 32'hA5);

        // 0x3C with stop bit 0, then break held low for 50 cycles
        send_frame(8'h3C, 1'b0, CPB * 100);
        Rx = 1'b0;
        wait_cycles(50);
        check("ferr_pulses", 32'(err_cnt), 32'd1);
        check("ferr_busy", 32'(Ocupado), 32'd1);
        check("ferr_data", 32'(data), 32'hA5);
        check("ferr_rdy", 32'(rdy_cnt), 32'd1);
        Rx = 1'b1;
        wait_cycles(200);
        check("ferr_recover_idle", 32'(Ocupado), 32'd0);
        check("ferr_no_new_frame", 32'(rdy_cnt), 32'd1);
        check("ferr_err_once", 32'(err_cnt), 32'd1);

        // Back-to-back 0x00, 0xFF, 0x81
        base = rdy_cnt;
        send_frame(8'h00, 1'b1, CPB * 100);
        send_frame(8'hFF, 1'b1, CPB * 100);
        send_frame(8'h81, 1'b1, CPB * 100);
        wait_cycles(20);
        check("b2b_pulses", 32'(rdy_cnt - base), 32'd3);
        check("b2b_0", 32'(rx_q[base]), 32'h00);
        check("b2b_1", 32'(rx_q[base+1]), 32'hFF);
        check("b2b_2", 32'(rx_q[base+2]), 32'h81);
        check("b2b_data", 32'(data), 32'h81);

        // Reset in the middle of bit 4 of 0x55
        base = rdy_cnt;
        Rx = 1'b0; wait_cycles(CPB);
        Rx = 1'b1; wait_cycles(CPB);
        Rx = 1'b0; wait_cycles(CPB);
        Rx = 1'b1; wait_cycles(CPB);
        Rx = 1'b0; wait_cycles(CPB);
        Rx = 1'b1; wait_cycles(CPB / 2);
        check("pre_rst_busy", 32'(Ocupado), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(Ocupado), 32'd0);
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_rdy", 32'(RxListo), 32'd0);
        wait_cycles(4);
        reset = 1'b1;
        wait_cycles(3);
        send_frame(8'h12, 1'b1, CPB * 100);
        wait_cycles(20);
        check("postrst_pulses", 32'(rdy_cnt - base), 32'd1);
        check("postrst_data", 32'(data), 32'h12);

        // 0x5A with +3% and -3% baud skew
        base = rdy_cnt;
        send_frame(8'h5A, 1'b1, CPB * 103);
        wait_cycles(20);
        check("skew_slow_pulses", 32'(rdy_cnt - base), 32'd1);
        check("skew_slow_data", 32'(data), 32'h5A);
        check_latency("skew_slow_latency");
        data_clear_frame();
        base = rdy_cnt;
        send_frame(8'h5A, 1'b1, CPB * 97);
        wait_cycles(20);
        check("skew_fast_pulses", 32'(rdy_cnt - base), 32'd1);
        check("skew_fast_data", 32'(data), 32'h5A);
        check_latency("skew_fast_latency");

        // Pulse hygiene over the whole run
        check("no_overlap", 32'(overlap_cnt), 32'd0);
        check("rdy_width", 32'(long_rdy_cnt), 32'd0);
        check("err_width", 32'(long_err_cnt), 32'd0);
        check("total_err", 32'(err_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Sends a different byte between the two skew frames so the second
    // skew frame's data check cannot pass on a stale value.
    task automatic data_clear_frame();
        send_frame(8'hC3, 1'b1, CPB * 100);
        wait_cycles(20);
        check("sep_data", 32'(data), 32'hC3);
    endtask

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
